rot_sequencer: RTL and testbench

ROT_SEQUENCER -- requirements
Module: rot_sequencer

---
 rtl/rot_sequencer_pkg.sv | 14 +
 rtl/rot_sequencer_barrel.sv | 25 ++
 rtl/rot_sequencer.sv | 114 +++++++++++
 tb/tb_rot_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/rot_sequencer_pkg.sv
// rtl/rot_sequencer_pkg.sv - shared types and constants for the rotate sequencer
package rot_sequencer_pkg;

  localparam int DATA_W = 8;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/rot_sequencer_barrel.sv
// rtl/rot_sequencer_barrel.sv - combinational 8-bit rotator, right or left by 0..7
module barrel
  import rot_sequencer_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [2:0]        ctr,
  input  logic              dir,
  output logic [DATA_W-1:0] out
);

  logic [2*DATA_W-1:0] dbl_l;
  logic [2*DATA_W-1:0] dbl_r;

  // Doubling the word lets a plain shift carry the wrapped bits into the kept half.
  always_comb begin
    dbl_l = {data, data} << ctr;
    dbl_r = {data, data} >> ctr;
    if (dir == DIR_LEFT) begin
      out = dbl_l[2*DATA_W-1:DATA_W];
    end else begin
      out = dbl_r[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/rot_sequencer.sv
// rtl/rot_sequencer.sv - emits N successively rotated copies of a seed word per command
module rot_sequencer
  import rot_sequencer_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [2:0]        cmd_step,
  input  logic              cmd_dir,
  input  logic [CNT_W-1:0]  cmd_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam logic [CNT_W:0] CNT_FULL = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0] CNT_ONE  = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0] CNT_TWO  = CNT_ONE + CNT_ONE;

  state_e              state_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic                out_last_q;
  logic [2:0]          step_q;
  logic                dir_q;
  logic [CNT_W:0]      cnt_q;

  logic [CNT_W:0]      cnt_load_d;
  logic [DATA_W-1:0]   rot_data_d;
  logic [2:0]          rot_ctr_d;
  logic                rot_dir_d;
  logic [DATA_W-1:0]   rot_out;
  logic                accept;
  logic                advance;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  assign accept  = cmd_valid && cmd_ready;
  assign advance = (state_q == RUN) && out_valid_q && out_ready;

  // A zero count field stands for the full 2**CNT_W words.
  assign cnt_load_d = (cmd_count == '0) ? CNT_FULL : {1'b0, cmd_count};

  // In IDLE the rotator serves the incoming command; in RUN it steps the held word.
  always_comb begin
    rot_data_d = out_data_q;
    rot_ctr_d  = step_q;
    rot_dir_d  = dir_q;
    if (state_q == IDLE) begin
      rot_data_d = cmd_data;
      rot_ctr_d  = cmd_step;
      rot_dir_d  = cmd_dir;
    end
  end

  barrel u_barrel (
    .data (rot_data_d),
    .ctr  (rot_ctr_d),
    .dir  (rot_dir_d),
    .out  (rot_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      step_q      <= '0;
      dir_q       <= DIR_RIGHT;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            step_q      <= cmd_step;
            dir_q       <= cmd_dir;
            cnt_q       <= cnt_load_d;
            out_data_q  <= rot_out;
            out_valid_q <= 1'b1;
            out_last_q  <= (cnt_load_d == CNT_ONE);
            state_q     <= RUN;
          end
        end
        RUN: begin
          if (advance) begin
            if (cnt_q == CNT_ONE) begin
              cnt_q       <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= IDLE;
            end else begin
              cnt_q       <= cnt_q - CNT_ONE;
              out_data_q  <= rot_out;
              out_last_q  <= (cnt_q == CNT_TWO);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rot_sequencer.sv
// tb/tb_rot_sequencer.sv - directed self-checking bench for rot_sequencer
module tb_rot_sequencer;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_data;
  logic [2:0]       cmd_step;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;
  logic             busy;

  int n_checks;
  int n_fail;

  rot_sequencer #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_step  (cmd_step),
    .cmd_dir   (cmd_dir),
    .cmd_count (cmd_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; issues the command for one edge and returns at the next negedge.
  task automatic send_cmd(input logic [7:0] d, input logic [2:0] s, input logic dr,
                          input logic [CNT_W-1:0] c);
    check_eq("cmd_ready_before_cmd", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_step  = s;
    cmd_dir   = dr;
    cmd_count = c;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Waits (bounded) for a valid word, checks it, and lets it handshake with out_ready=1.
  task automatic expect_word(input string tag, input logic [7:0] d, input logic l);
    int waited;
    waited = 0;
    out_ready = 1'b1;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq({tag, "_valid"}, out_valid, 1'b1);
    check_eq({tag, "_data"}, out_data, d);
    check_eq({tag, "_last"}, out_last, l);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] alt;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    cmd_step  = '0;
    cmd_dir   = 1'b0;
    cmd_count = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_last", out_last, 1'b0);
    check_eq("rst_out_data", out_data, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_cmd_ready", cmd_ready, 1'b1);

    // Rotate left by 1, three words.
    out_ready = 1'b1;
    send_cmd(8'h81, 3'd1, 1'b1, 4'd3);
    check_eq("t1_busy", busy, 1'b1);
    check_eq("t1_cmd_ready_run", cmd_ready, 1'b0);
    expect_word("t1_w1", 8'h03, 1'b0);
    expect_word("t1_w2", 8'h06, 1'b0);
    expect_word("t1_w3", 8'h0C, 1'b1);
    check_eq("t1_busy_after", busy, 1'b0);
    check_eq("t1_valid_after", out_valid, 1'b0);
    check_eq("t1_last_after", out_last, 1'b0);

    // Rotate right by 2 wraps back to the seed.
    send_cmd(8'h01, 3'd2, 1'b0, 4'd4);
    expect_word("t2_w1", 8'h40, 1'b0);
    expect_word("t2_w2", 8'h10, 1'b0);
    expect_word("t2_w3", 8'h04, 1'b0);
    expect_word("t2_w4", 8'h01, 1'b1);
    check_eq("t2_busy_after", busy, 1'b0);

    // Count field 0 means 16 words.
    send_cmd(8'hA5, 3'd4, 1'b1, 4'd0);
    alt = 8'h5A;
    for (int i = 0; i < 16; i++) begin
      expect_word($sformatf("t3_w%0d", i + 1), alt, (i == 15));
      alt = ~alt;
    end
    check_eq("t3_valid_after", out_valid, 1'b0);

    // Backpressure holds the word; a command during RUN is ignored.
    out_ready = 1'b0;
    send_cmd(8'h3C, 3'd3, 1'b1, 4'd2);
    cmd_valid = 1'b1;
    cmd_data  = 8'hFF;
    cmd_step  = 3'd1;
    cmd_count = 4'd7;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("t4_hold%0d_data", i), out_data, 8'hE1);
      check_eq($sformatf("t4_hold%0d_valid", i), out_valid, 1'b1);
      check_eq($sformatf("t4_hold%0d_last", i), out_last, 1'b0);
      check_eq($sformatf("t4_hold%0d_ready", i), cmd_ready, 1'b0);
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    expect_word("t4_w1", 8'hE1, 1'b0);
    expect_word("t4_w2", 8'h0F, 1'b1);
    @(negedge clk);
    check_eq("t4_no_stray_cmd", out_valid, 1'b0);

    // Step 0 repeats the seed.
    send_cmd(8'hF0, 3'd0, 1'b0, 4'd2);
    expect_word("t5_w1", 8'hF0, 1'b0);
    expect_word("t5_w2", 8'hF0, 1'b1);

    // Single-word command, rotate right by 7.
    send_cmd(8'h96, 3'd7, 1'b0, 4'd1);
    expect_word("t6_w1", 8'h2D, 1'b1);
    check_eq("t6_busy_after", busy, 1'b0);

    // Reset during word 2 aborts the command.
    send_cmd(8'h11, 3'd1, 1'b1, 4'd5);
    expect_word("t7_w1", 8'h22, 1'b0);
    check_eq("t7_w2_data", out_data, 8'h44);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("t7_rst_valid", out_valid, 1'b0);
    check_eq("t7_rst_data", out_data, 8'h00);
    check_eq("t7_rst_last", out_last, 1'b0);
    check_eq("t7_rst_busy", busy, 1'b0);
    @(negedge clk);
    check_eq("t7_ready_after", cmd_ready, 1'b1);
    check_eq("t7_no_more_words", out_valid, 1'b0);
    send_cmd(8'h80, 3'd1, 1'b0, 4'd2);
    expect_word("t7_new_w1", 8'h40, 1'b0);
    expect_word("t7_new_w2", 8'h20, 1'b1);
    check_eq("t7_new_busy_after", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
